reg_scoreboard: RTL

- Per-register write-pending scoreboard that sequences issue out of the decode stage.
- Replaces the three-way destination-index comparator interlock: tracks every in-flight register write from issue to writeback and raises stall while a source operand is still pending.
- Supports ID/EX squash on branch redirect, and reports pipeline drain for ebreak halt.

---
 rtl/reg_scoreboard_pkg.sv | 20 ++
 rtl/reg_scoreboard_if.sv | 59 +++++
 rtl/reg_scoreboard_sb_counter.sv | 55 +++++
 rtl/reg_scoreboard.sv | 101 ++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sys_defs (package)
//  Description : Shared register-file definitions for the issue scoreboard:
//                register-index width, the hardwired zero register and the
//                default pending-write counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sys_defs;

  localparam int REG_IDX_W    = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int CNT_W_DEF    = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard_if
//  Description : Decode / squash / writeback bundle into the scoreboard and
//                its stall, issue and status outputs back to the pipeline.
//                The pipeline side uses the master modport, the scoreboard
//                uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if
  import sys_defs::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
);

  // Decode stage
  logic                id_valid_inst;
  logic                id_uses_ra;
  logic                id_uses_rb;
  reg_idx_t            id_ra_idx;
  reg_idx_t            id_rb_idx;
  logic                id_reg_wr;
  reg_idx_t            id_dest_idx;

  // ID/EX squash of the instruction issued in the previous cycle
  logic                squash;
  logic                squash_reg_wr;
  reg_idx_t            squash_dest_idx;

  // Writeback stage
  logic                wb_valid;
  logic                wb_reg_wr;
  reg_idx_t            wb_dest_idx;

  // Scoreboard outputs
  logic                stall;
  logic                issue;
  logic [NUM_REGS-1:0] busy_vec;
  logic                pipe_idle;
  logic                err_underflow;

  modport master (
    output id_valid_inst, id_uses_ra, id_uses_rb, id_ra_idx, id_rb_idx,
           id_reg_wr, id_dest_idx,
           squash, squash_reg_wr, squash_dest_idx,
           wb_valid, wb_reg_wr, wb_dest_idx,
    input  stall, issue, busy_vec, pipe_idle, err_underflow
  );

  modport slave (
    input  id_valid_inst, id_uses_ra, id_uses_rb, id_ra_idx, id_rb_idx,
           id_reg_wr, id_dest_idx,
           squash, squash_reg_wr, squash_dest_idx,
           wb_valid, wb_reg_wr, wb_dest_idx,
    output stall, issue, busy_vec, pipe_idle, err_underflow
  );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sb_counter
//  Description : Pending-write counter for one architectural register.
//                One increment and up to two decrements per cycle are folded
//                into a single update; a net result below zero clamps at zero
//                and pulses underflow for that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,        // asynchronous, active-low
  input  logic inc,
  input  logic dec_a,
  input  logic dec_b,
  output logic busy,
  output logic full,
  output logic underflow
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W:0]   w_up;
  logic [CNT_W:0]   w_down;
  logic [CNT_W:0]   w_diff;

  // Net change in -2..+1: add first, then subtract, clamp if it goes negative
  always_comb begin
    w_up      = {1'b0, r_cnt} + (CNT_W+1)'(inc);
    w_down    = (CNT_W+1)'(dec_a) + (CNT_W+1)'(dec_b);
    w_diff    = w_up - w_down;
    underflow = 1'b0;
    w_cnt_nxt = w_diff[CNT_W-1:0];
    if (w_up < w_down) begin
      underflow = 1'b1;
      w_cnt_nxt = '0;
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign busy = |r_cnt;
  assign full = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-register write-pending scoreboard gating issue out of
//                decode. Each in-flight register write is counted from issue
//                to writeback (or squash); decode stalls while a source is
//                pending or the destination counter is saturated. There is
//                no write-through: a same-cycle writeback still stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import sys_defs::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,   // asynchronous, active-low
  reg_scoreboard_if.slave  sb
);

  logic                w_inc;
  logic                w_dec_wb;
  logic                w_dec_sq;
  logic [NUM_REGS-1:1] w_inc_vec;
  logic [NUM_REGS-1:1] w_dec_wb_vec;
  logic [NUM_REGS-1:1] w_dec_sq_vec;
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_full;
  logic [NUM_REGS-1:1] w_uflow;
  logic                w_raw_a;
  logic                w_raw_b;
  logic                w_sat;
  logic                w_stall;
  logic                w_issue;
  logic                r_err_underflow;

  // Hazards look only at registered counters; x0 is never busy or full
  always_comb begin
    w_raw_a = sb.id_uses_ra & (sb.id_ra_idx != ZERO_REG) & w_busy[sb.id_ra_idx];
    w_raw_b = sb.id_uses_rb & (sb.id_rb_idx != ZERO_REG) & w_busy[sb.id_rb_idx];
    w_sat   = sb.id_reg_wr & (sb.id_dest_idx != ZERO_REG) & w_full[sb.id_dest_idx];
    // A squash kills the decode instruction too, so it neither stalls nor issues
    w_stall = sb.id_valid_inst & ~sb.squash & (w_raw_a | w_raw_b | w_sat);
    w_issue = sb.id_valid_inst & ~sb.squash & ~w_stall;
  end

  // Counter events for this cycle
  always_comb begin
    w_inc    = w_issue & sb.id_reg_wr & (sb.id_dest_idx != ZERO_REG);
    w_dec_wb = sb.wb_valid & sb.wb_reg_wr & (sb.wb_dest_idx != ZERO_REG);
    w_dec_sq = sb.squash & sb.squash_reg_wr & (sb.squash_dest_idx != ZERO_REG);
  end

  // One-hot steering of each event to its register counter
  always_comb begin
    w_inc_vec    = '0;
    w_dec_wb_vec = '0;
    w_dec_sq_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_inc_vec[i]    = w_inc    & (sb.id_dest_idx     == REG_IDX_W'(i));
      w_dec_wb_vec[i] = w_dec_wb & (sb.wb_dest_idx     == REG_IDX_W'(i));
      w_dec_sq_vec[i] = w_dec_sq & (sb.squash_dest_idx == REG_IDX_W'(i));
    end
  end

  assign w_busy[0] = 1'b0;
  assign w_full[0] = 1'b0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_inc_vec[gi]),
      .dec_a     (w_dec_wb_vec[gi]),
      .dec_b     (w_dec_sq_vec[gi]),
      .busy      (w_busy[gi]),
      .full      (w_full[gi]),
      .underflow (w_uflow[gi])
    );
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_underflow <= 1'b0;
    end else if (|w_uflow) begin
      r_err_underflow <= 1'b1;
    end
  end

  assign sb.stall         = w_stall;
  assign sb.issue         = w_issue;
  assign sb.busy_vec      = w_busy;
  assign sb.pipe_idle     = ~|w_busy;
  assign sb.err_underflow = r_err_underflow;

endmodule
`default_nettype wire
